pseudo_spi_in_intf: RTL and testbench
=====================================

# pseudo_spi_in_intf

Readback companion to the pseudo-SPI output interface. It pulses SEL so the analog device loads its result chain. It then generates the same two-phase SCLK1/SCLK2 bit clocks, captures SPI_SI one bit per bit period and packs the bits into MEMORY_DATA_WIDTH words. Each completed word is written to SRAM at a descending address starting at ADDR_BGN, and spi_is_done is raised when the last word is stored.

## Interface
- MEMORY_DATA_WIDTH, 8, SRAM word width (W); bits captured per word.
- MEMORY_ADDR_WIDTH, 9, SRAM address width.
- RESERVED_DATA_LEN, 8, width of DATA_LEN.
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  reset; one clock, reset is synchronous and active-high.
- BGN  input  1  level run request; high starts/continues, low aborts/returns to idle.
- ADDR_BGN  input  MEMORY_ADDR_WIDTH  first (highest) SRAM address written.
- DATA_LEN  input  RESERVED_DATA_LEN  words to capture minus one (0 = one word).
- SPI_SI  input  1  serial data from the analog device.
- SCLK1  output  1  phase-1 bit clock.
- SCLK2  output  1  phase-2 bit clock, non-overlapping with SCLK1.
- SEL  output  1  device parallel-load/select strobe.
- PO  output  MEMORY_DATA_WIDTH  write data to SRAM.
- A  output  MEMORY_ADDR_WIDTH  SRAM address; 0 whenever CEN=1.
- CEN  output  1  SRAM chip enable, active low.
- D_WE  output  1  SRAM write enable, low = write.
- spi_is_done  output  1  capture complete.

## Operation
- All outputs are decoded from registers; no combinational path from inputs to outputs.
- States:
  - IDLE: exits to LOAD when BGN=1. On that edge latch ADDR_BGN into addr and DATA_LEN into words_left; clear shift register and bit counter.
  - LOAD: SEL=1 for 2 cycles, then SHIFT.
  - SHIFT: one bit period is 5 cycles, with the phase counter running 4,3,2,1,0.
    - SCLK1=1 in phase 3; SCLK2=1 in phase 1.
    - SPI_SI is sampled at the posedge ending phase 0.
    - Default shift is sr <= {SPI_SI, sr[W-1:1]}, so the first bit received lands in bit 0, matching the output interface's LSB-first order.
    - After W bits go to WRITE.
  - WRITE: one cycle with CEN=0, D_WE=0, A=addr, PO=sr. Then NEXT.
  - NEXT: one cycle.
    - If words_left==0, go to DONE.
    - Otherwise addr<=addr-1, words_left<=words_left-1, then SHIFT. There is no new SEL; the device chain is continuous.
  - DONE: spi_is_done=1, held while BGN=1. BGN=0 goes to IDLE.
- Address arithmetic is modulo 2^MEMORY_ADDR_WIDTH: 0 minus 1 wraps to all-ones silently.
- Abort: BGN=0 sampled in any state forces IDLE on that edge. A WRITE in progress on that edge is suppressed (CEN=1). Partial words are discarded.
- BGN must drop to 0 before a new run; BGN held high in DONE does not restart.

## Timing
- Reset values: SCLK1=0, SCLK2=0, SEL=0, PO=0, A=0, CEN=1, D_WE=1, spi_is_done=0, state=IDLE.
- RST has priority over BGN.
- The BGN edge to first SEL high is 1 cycle.
- Per word: 5·W cycles of SHIFT, plus 1 WRITE, plus 1 NEXT.
- The BGN sample edge to DONE entry is 2 + (DATA_LEN+1)·(5W+2) cycles. For W=8 this is 2 + 42·(DATA_LEN+1).
- SCLK1 and SCLK2 are never high together and are separated by ≥1 low cycle.
- SEL is never high during SHIFT.
- CEN=0 exactly one cycle per word; D_WE=0 only in that cycle.
- PO and A are stable for the whole CEN=0 cycle.

## Configuration
- PSEUDO_SPI_IN_MSB_FIRST_EN:
  - Defined: shift becomes sr <= {sr[W-2:0], SPI_SI}, so the first bit received lands in bit W-1.
  - Undefined (default): LSB-first as above.
- Nothing else changes, including timing and ports.

## Test plan
- Single word: RST, ADDR_BGN=0x010, DATA_LEN=0, SPI_SI bit sequence 1,0,1,0,0,1,0,1 -> one write at A=0x010, PO=0xA5; spi_is_done rises 44 cycles after the BGN sample.
- Three words: ADDR_BGN=0x100, DATA_LEN=2, words 0x3C,0xFF,0x00 -> writes 0x3C@0x100, 0xFF@0x0FF, 0x00@0x0FE, in order, 42 cycles apart. SEL pulses once at start.
- Wrap: ADDR_BGN=0x000, DATA_LEN=1 -> writes to 0x000 then 0x1FF; no error flag.
- Abort: BGN=0 during bit 4 of word 2 of a 4-word run -> IDLE next edge, only word 1 written. Outputs return to reset values; a fresh BGN restarts from ADDR_BGN.
- Mid-run RST=1 -> all outputs at reset values on the next edge, no pending write. Clock checker confirms SCLK1/SCLK2 never overlap.
- With PSEUDO_SPI_IN_MSB_FIRST_EN defined, SPI_SI 1,0,1,0,0,1,0,1 -> PO=0xA5. Sequence 1,1,0,0,0,0,0,0 -> PO=0xC0, versus 0x03 when undefined.

Source files
------------

// File: rtl/pseudo_spi_in_intf.sv
// Pseudo-SPI readback: SEL load strobe, two-phase bit clocks, word packing into SRAM.
// Define PSEUDO_SPI_IN_MSB_FIRST_EN to pack the first received bit into bit W-1.
module pseudo_spi_in_intf #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int RESERVED_DATA_LEN = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    input  logic                         SPI_SI,
    output logic                         SCLK1,
    output logic                         SCLK2,
    output logic                         SEL,
    output logic [MEMORY_DATA_WIDTH-1:0] PO,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic                         CEN,
    output logic                         D_WE,
    output logic                         spi_is_done
);

    localparam int W  = MEMORY_DATA_WIDTH;
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int LW = RESERVED_DATA_LEN;
    localparam int BW = $clog2(W) + 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
    localparam logic [2:0]    PH_START = 3'd4;
    localparam logic [2:0]    PH_SCLK1 = 3'd3;
    localparam logic [2:0]    PH_SCLK2 = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q,      state_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic [LW-1:0] words_left_q, words_left_d;
    logic [W-1:0]  sr_q,         sr_d;
    logic [BW-1:0] bit_cnt_q,    bit_cnt_d;
    logic [2:0]    phase_q,      phase_d;
    logic          load_cnt_q,   load_cnt_d;

    logic [W-1:0]  sr_shifted;

`ifdef PSEUDO_SPI_IN_MSB_FIRST_EN
    assign sr_shifted = {sr_q[W-2:0], SPI_SI};
`else
    assign sr_shifted = {SPI_SI, sr_q[W-1:1]};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            phase_q      <= '0;
            load_cnt_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            phase_q      <= phase_d;
            load_cnt_q   <= load_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        phase_d      = phase_q;
        load_cnt_d   = load_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (BGN) begin
                    state_d      = S_LOAD;
                    addr_d       = ADDR_BGN;
                    words_left_d = DATA_LEN;
                    sr_d         = '0;
                    bit_cnt_d    = '0;
                    load_cnt_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_cnt_q) begin
                    state_d = S_SHIFT;
                    phase_d = PH_START;
                end else begin
                    load_cnt_d = 1'b1;
                end
            end
            S_SHIFT: begin
                // Bit is captured on the edge that closes phase 0.
                if (phase_q == 3'd0) begin
                    sr_d    = sr_shifted;
                    phase_d = PH_START;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_WRITE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (words_left_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    addr_d       = addr_q - 1'b1;
                    words_left_d = words_left_q - 1'b1;
                    phase_d      = PH_START;
                    state_d      = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Dropping BGN aborts from anywhere; a write about to start is never entered.
        if (!BGN) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        SCLK1       = 1'b0;
        SCLK2       = 1'b0;
        SEL         = 1'b0;
        PO          = '0;
        A           = '0;
        CEN         = 1'b1;
        D_WE        = 1'b1;
        spi_is_done = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                SEL = 1'b1;
            end
            S_SHIFT: begin
                SCLK1 = (phase_q == PH_SCLK1);
                SCLK2 = (phase_q == PH_SCLK2);
            end
            S_WRITE: begin
                PO   = sr_q;
                A    = addr_q;
                CEN  = 1'b0;
                D_WE = 1'b0;
            end
            S_DONE: begin
                spi_is_done = 1'b1;
            end
            default: begin
                SEL = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pseudo_spi_in_intf.sv
// Directed bench for pseudo_spi_in_intf: a bit feeder on SCLK1, a bus monitor,
// and one task per scenario with hand-computed expectations.
`timescale 1ns/1ps
module tb_pseudo_spi_in_intf;

    localparam int W  = 8;
    localparam int AW = 9;
    localparam int LW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          BGN = 1'b0;
    logic [AW-1:0] ADDR_BGN = '0;
    logic [LW-1:0] DATA_LEN = '0;
    logic          SPI_SI = 1'b0;
    logic          SCLK1, SCLK2, SEL, CEN, D_WE, spi_is_done;
    logic [W-1:0]  PO;
    logic [AW-1:0] A;

    pseudo_spi_in_intf #(
        .MEMORY_DATA_WIDTH(W),
        .MEMORY_ADDR_WIDTH(AW),
        .RESERVED_DATA_LEN(LW)
    ) dut (
        .CLK(CLK), .RST(RST), .BGN(BGN), .ADDR_BGN(ADDR_BGN),
        .DATA_LEN(DATA_LEN), .SPI_SI(SPI_SI), .SCLK1(SCLK1),
        .SCLK2(SCLK2), .SEL(SEL), .PO(PO), .A(A), .CEN(CEN),
        .D_WE(D_WE), .spi_is_done(spi_is_done)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bgn_cyc = 0;
    bit mon_en = 1'b0;

    logic          bits_q[$];
    logic [AW-1:0] wr_a[$];
    logic [W-1:0]  wr_d[$];
    int            wr_c[$];
    int            sel_hi = 0;
    int            sel_rise = 0;
    logic          prev_s1 = 1'b0, prev_s2 = 1'b0, prev_sel = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Device model: presents the next bit on each SCLK1 rise.
    initial begin
        forever begin
            @(posedge SCLK1);
            #1;
            if (bits_q.size() > 0) SPI_SI = bits_q.pop_front();
            else SPI_SI = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                total++;
                if (SCLK1 && SCLK2) begin
                    bad++;
                    $display("FAIL clk_overlap cyc=%0d sclk1=%b sclk2=%b want not both", cyc, SCLK1, SCLK2);
                end
                total++;
                if ((SCLK1 && prev_s2) || (SCLK2 && prev_s1)) begin
                    bad++;
                    $display("FAIL clk_gap cyc=%0d sclk1=%b sclk2=%b want low cycle between", cyc, SCLK1, SCLK2);
                end
                total++;
                if (SEL && (SCLK1 || SCLK2)) begin
                    bad++;
                    $display("FAIL sel_in_shift cyc=%0d sel=%b want 0 while clocking", cyc, SEL);
                end
                if (CEN === 1'b1) begin
                    total++;
                    if (A !== '0 || D_WE !== 1'b1) begin
                        bad++;
                        $display("FAIL idle_bus cyc=%0d A=%h D_WE=%b want A=0 D_WE=1", cyc, A, D_WE);
                    end
                end else begin
                    total++;
                    if (D_WE !== 1'b0) begin
                        bad++;
                        $display("FAIL write_we cyc=%0d D_WE=%b want 0", cyc, D_WE);
                    end
                    wr_a.push_back(A);
                    wr_d.push_back(PO);
                    wr_c.push_back(cyc);
                end
                if (SEL && !prev_sel) sel_rise++;
                if (SEL) sel_hi++;
                prev_s1  = SCLK1;
                prev_s2  = SCLK2;
                prev_sel = SEL;
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w);
`ifdef PSEUDO_SPI_IN_MSB_FIRST_EN
        for (int i = W - 1; i >= 0; i--) bits_q.push_back(w[i]);
`else
        for (int i = 0; i < W; i++) bits_q.push_back(w[i]);
`endif
    endtask

    task automatic start_run(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        @(negedge CLK);
        wr_a.delete();
        wr_d.delete();
        wr_c.delete();
        sel_hi   = 0;
        sel_rise = 0;
        ADDR_BGN = addr;
        DATA_LEN = len;
        BGN      = 1'b1;
        bgn_cyc  = cyc + 1;
    endtask

    task automatic wait_done(input int budget, input int exp_lat, input string name);
        int i;
        i = 0;
        while (i < budget && spi_is_done !== 1'b1) begin
            @(negedge CLK);
            i++;
        end
        total++;
        if (spi_is_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout done=%b after %0d cycles want 1", name, spi_is_done, budget);
        end else if (cyc - bgn_cyc != exp_lat) begin
            bad++;
            $display("FAIL %s_latency got=%0d want=%0d", name, cyc - bgn_cyc, exp_lat);
        end
    endtask

    task automatic end_run(input string name);
        @(negedge CLK);
        BGN = 1'b0;
        @(negedge CLK);
        total++;
        if (spi_is_done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_clear got=%b want=0", name, spi_is_done);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if ({SCLK1, SCLK2, SEL, CEN, D_WE, spi_is_done} !== 6'b000110) begin
            bad++;
            $display("FAIL %s_ctrl got=%b want=000110", name,
                     {SCLK1, SCLK2, SEL, CEN, D_WE, spi_is_done});
        end
        total++;
        if (PO !== '0 || A !== '0) begin
            bad++;
            $display("FAIL %s_bus PO=%h A=%h want 0/0", name, PO, A);
        end
    endtask

    task automatic check_write(input int idx, input logic [AW-1:0] ea,
                               input logic [W-1:0] ed, input string name);
        total++;
        if (idx >= wr_a.size()) begin
            bad++;
            $display("FAIL %s_missing write %0d of %0d", name, idx, wr_a.size());
        end else if (wr_a[idx] !== ea || wr_d[idx] !== ed) begin
            bad++;
            $display("FAIL %s got=%h@%h want=%h@%h", name, wr_d[idx], wr_a[idx], ed, ea);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        BGN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("reset");
        RST = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single;
        logic seq[$] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bits_q = seq;
        start_run(9'h010, 8'd0);
        @(negedge CLK);
        total++;
        if (SEL !== 1'b1) begin
            bad++;
            $display("FAIL single_sel_first got=%b want=1", SEL);
        end
        wait_done(100, 44, "single");
        total++;
        if (wr_a.size() != 1) begin
            bad++;
            $display("FAIL single_count got=%0d want=1", wr_a.size());
        end
        check_write(0, 9'h010, 8'hA5, "single_data");
        total++;
        if (wr_c.size() > 0 && wr_c[0] - bgn_cyc != 42) begin
            bad++;
            $display("FAIL single_write_cyc got=%0d want=42", wr_c[0] - bgn_cyc);
        end
        total++;
        if (sel_hi != 2) begin
            bad++;
            $display("FAIL single_sel_len got=%0d want=2", sel_hi);
        end
        end_run("single");
    endtask

    task automatic test_three;
        bits_q.delete();
        push_word(8'h3C);
        push_word(8'hFF);
        push_word(8'h00);
        start_run(9'h100, 8'd2);
        wait_done(200, 128, "three");
        total++;
        if (wr_a.size() != 3) begin
            bad++;
            $display("FAIL three_count got=%0d want=3", wr_a.size());
        end
        check_write(0, 9'h100, 8'h3C, "three_w0");
        check_write(1, 9'h0FF, 8'hFF, "three_w1");
        check_write(2, 9'h0FE, 8'h00, "three_w2");
        total++;
        if (wr_c.size() == 3 && (wr_c[1] - wr_c[0] != 42 || wr_c[2] - wr_c[1] != 42)) begin
            bad++;
            $display("FAIL three_spacing got=%0d,%0d want=42,42", wr_c[1] - wr_c[0], wr_c[2] - wr_c[1]);
        end
        total++;
        if (sel_rise != 1) begin
            bad++;
            $display("FAIL three_sel_pulses got=%0d want=1", sel_rise);
        end
        repeat (10) @(negedge CLK);
        total++;
        if (spi_is_done !== 1'b1 || wr_a.size() != 3 || sel_rise != 1) begin
            bad++;
            $display("FAIL three_hold done=%b writes=%0d sel=%0d want 1/3/1",
                     spi_is_done, wr_a.size(), sel_rise);
        end
        end_run("three");
    endtask

    task automatic test_wrap;
        bits_q.delete();
        push_word(8'h5A);
        push_word(8'h81);
        start_run(9'h000, 8'd1);
        wait_done(150, 86, "wrap");
        check_write(0, 9'h000, 8'h5A, "wrap_w0");
        check_write(1, 9'h1FF, 8'h81, "wrap_w1");
        end_run("wrap");
    endtask

    task automatic test_abort;
        bits_q.delete();
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        start_run(9'h050, 8'd3);
        while (cyc < bgn_cyc + 61) @(negedge CLK);
        BGN = 1'b0;
        @(negedge CLK);
        check_idle_outputs("abort");
        repeat (100) @(negedge CLK);
        total++;
        if (wr_a.size() != 1) begin
            bad++;
            $display("FAIL abort_count got=%0d want=1", wr_a.size());
        end
        check_write(0, 9'h050, 8'h11, "abort_w0");
        bits_q.delete();
        push_word(8'h96);
        start_run(9'h050, 8'd0);
        wait_done(100, 44, "restart");
        check_write(0, 9'h050, 8'h96, "restart_w0");
        end_run("restart");
    endtask

    task automatic test_reset_mid;
        bits_q.delete();
        push_word(8'h77);
        push_word(8'h88);
        start_run(9'h020, 8'd1);
        while (cyc < bgn_cyc + 41) @(negedge CLK);
        RST = 1'b1;
        BGN = 1'b0;
        @(negedge CLK);
        check_idle_outputs("midrst");
        RST = 1'b0;
        repeat (60) @(negedge CLK);
        total++;
        if (wr_a.size() != 0) begin
            bad++;
            $display("FAIL midrst_writes got=%0d want=0", wr_a.size());
        end
    endtask

    task automatic test_bit_order;
        logic seq[$] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] exp_po;
`ifdef PSEUDO_SPI_IN_MSB_FIRST_EN
        exp_po = 8'hC0;
`else
        exp_po = 8'h03;
`endif
        bits_q = seq;
        start_run(9'h033, 8'd0);
        wait_done(100, 44, "order");
        check_write(0, 9'h033, exp_po, "order_w0");
        end_run("order");
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_bit_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
